// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: owns the fetch PC, issues in-order imem requests and
// buffers responses with their PC and prediction metadata for decode.
module fetch_pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BUF_DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,

    output logic [XLEN-1:0] pred_lookup_pc_o,
    input  logic [XLEN-1:0] pred_pc_i,
    input  logic            pred_taken_i,
    input  logic            pred_v_i,

    input  logic            bu_redirect_i,
    input  logic [XLEN-1:0] bu_redirect_pc_i,
    input  logic            csr_redirect_i,
    input  logic [XLEN-1:0] csr_redirect_pc_i,

    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,

    output logic            if_valid_o,
    output logic [31:0]     if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic            if_pred_taken_o,
    output logic [XLEN-1:0] if_pred_pc_o,
    input  logic            dec_ready_i
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [XLEN-1:0]  pc_reg,      pc_next;
    logic [PTR_W-1:0] head_reg,    head_next;
    logic [PTR_W-1:0] tail_reg,    tail_next;
    logic [PTR_W-1:0] fill_reg,    fill_next;
    logic [CNT_W-1:0] occ_reg,     occ_next;
    logic [CNT_W-1:0] pend_reg,    pend_next;
    logic [CNT_W-1:0] discard_reg, discard_next;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [CNT_W:0]  inflight_sum;
    logic            take;
    logic            grant;
    logic            fill;
    logic            drop_resp;
    logic            pop;

    logic [XLEN-1:0] entry_pc        [BUF_DEPTH];
    logic            entry_pred_taken[BUF_DEPTH];
    logic [XLEN-1:0] entry_pred_pc   [BUF_DEPTH];
    logic [31:0]     entry_instr     [BUF_DEPTH];

    // CSR redirect outranks the branch unit; targets are word aligned on load.
    assign redirect    = bu_redirect_i | csr_redirect_i;
    assign redirect_pc = (csr_redirect_i ? csr_redirect_pc_i : bu_redirect_pc_i)
                         & ~XLEN'(3);

    // Requests still in flight whose data will be dropped also hold a slot,
    // so responses never need backpressure.
    assign inflight_sum = {1'b0, occ_reg} + {1'b0, discard_reg};
    assign imem_req_o   = ~reset & ~redirect
                          & (inflight_sum < (CNT_W+1)'(BUF_DEPTH));
    assign imem_addr_o      = pc_reg;
    assign pred_lookup_pc_o = pc_reg;

    assign take      = pred_v_i & pred_taken_i;
    assign grant     = imem_req_o & imem_gnt_i;
    assign drop_resp = imem_rvalid_i & (discard_reg != '0);
    assign fill      = imem_rvalid_i & (discard_reg == '0) & ~redirect;

    // Entries fill in allocation order, so the head is filled exactly when
    // more entries are allocated than are still waiting for data.
    assign if_valid_o      = ~reset & (occ_reg > pend_reg);
    assign pop             = if_valid_o & dec_ready_i;
    assign if_instr_o      = entry_instr[head_reg];
    assign if_pc_o         = entry_pc[head_reg];
    assign if_pred_taken_o = entry_pred_taken[head_reg];
    assign if_pred_pc_o    = entry_pred_pc[head_reg];

    always_comb begin
        pc_next      = pc_reg;
        head_next    = head_reg;
        tail_next    = tail_reg;
        fill_next    = fill_reg;
        occ_next     = occ_reg;
        pend_next    = pend_reg;
        discard_next = discard_reg;

        if (redirect) begin
            pc_next      = redirect_pc;
            head_next    = '0;
            tail_next    = '0;
            fill_next    = '0;
            occ_next     = '0;
            pend_next    = '0;
            // Every unfilled entry still has a response coming; one arriving
            // now is consumed here.
            discard_next = discard_reg + pend_reg - CNT_W'(imem_rvalid_i);
        end else begin
            if (grant) begin
                pc_next   = take ? pred_pc_i : pc_reg + XLEN'(4);
                tail_next = tail_reg + PTR_W'(1);
            end
            if (fill) begin
                fill_next = fill_reg + PTR_W'(1);
            end
            if (pop) begin
                head_next = head_reg + PTR_W'(1);
            end
            if (drop_resp) begin
                discard_next = discard_reg - CNT_W'(1);
            end
            occ_next  = occ_reg + CNT_W'(grant) - CNT_W'(pop);
            pend_next = pend_reg + CNT_W'(grant) - CNT_W'(fill);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg      <= RESET_VECTOR;
            head_reg    <= '0;
            tail_reg    <= '0;
            fill_reg    <= '0;
            occ_reg     <= '0;
            pend_reg    <= '0;
            discard_reg <= '0;
        end else begin
            pc_reg      <= pc_next;
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            fill_reg    <= fill_next;
            occ_reg     <= occ_next;
            pend_reg    <= pend_next;
            discard_reg <= discard_next;
        end
    end

    // Payload storage carries no reset; validity lives entirely in the counters.
    genvar gi;
    generate
        for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
            logic [XLEN-1:0] pc_store_reg;
            logic            taken_store_reg;
            logic [XLEN-1:0] target_store_reg;
            logic [31:0]     instr_store_reg;

            always_ff @(posedge clk) begin
                if (grant && (tail_reg == PTR_W'(gi))) begin
                    pc_store_reg     <= pc_reg;
                    taken_store_reg  <= take;
                    target_store_reg <= pred_pc_i;
                end
                if (fill && (fill_reg == PTR_W'(gi))) begin
                    instr_store_reg <= imem_rdata_i;
                end
            end

            assign entry_pc[gi]         = pc_store_reg;
            assign entry_pred_taken[gi] = taken_store_reg;
            assign entry_pred_pc[gi]    = target_store_reg;
            assign entry_instr[gi]      = instr_store_reg;
        end
    endgenerate

`ifndef SYNTHESIS
    rvalid_has_owner: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid_i |-> ((pend_reg != '0) || (discard_reg != '0)));
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios plus random traffic, all checked
// each cycle against a queue-based model of the fetch buffer.
module tb_fetch_pc_gen;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pred_lookup_pc_o;
    logic [31:0] pred_pc_i;
    logic        pred_taken_i;
    logic        pred_v_i;
    logic        bu_redirect_i;
    logic [31:0] bu_redirect_pc_i;
    logic        csr_redirect_i;
    logic [31:0] csr_redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_pred_taken_o;
    logic [31:0] if_pred_pc_o;
    logic        dec_ready_i;

    fetch_pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .BUF_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .pred_lookup_pc_o  (pred_lookup_pc_o),
        .pred_pc_i         (pred_pc_i),
        .pred_taken_i      (pred_taken_i),
        .pred_v_i          (pred_v_i),
        .bu_redirect_i     (bu_redirect_i),
        .bu_redirect_pc_i  (bu_redirect_pc_i),
        .csr_redirect_i    (csr_redirect_i),
        .csr_redirect_pc_i (csr_redirect_pc_i),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_gnt_i        (imem_gnt_i),
        .imem_rvalid_i     (imem_rvalid_i),
        .imem_rdata_i      (imem_rdata_i),
        .if_valid_o        (if_valid_o),
        .if_instr_o        (if_instr_o),
        .if_pc_o           (if_pc_o),
        .if_pred_taken_o   (if_pred_taken_o),
        .if_pred_pc_o      (if_pred_pc_o),
        .dec_ready_i       (dec_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] ppc;
        logic        filled;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    int          m_disc;
    logic [31:0] m_pc;

    logic [31:0] gr_addr[$];
    logic [31:0] dv_pc[$];
    logic        dv_tk[$];
    logic [31:0] dv_ppc[$];

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] EXP_B [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    localparam logic [31:0] EXP_C [5] = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        gr_addr.delete();
        dv_pc.delete();
        dv_tk.delete();
        dv_ppc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bu_redirect_i = 1'b0;  csr_redirect_i = 1'b0;
        pred_v_i = 1'b0;       pred_taken_i = 1'b0;
        imem_gnt_i = 1'b0;     imem_rvalid_i = 1'b0;
        dec_ready_i = 1'b0;
        #1;
        chk("reset_req", {31'b0, imem_req_o}, 32'd0);
        chk("reset_valid", {31'b0, if_valid_o}, 32'd0);
        mq.delete();
        m_disc = 0;
        m_pc   = RV;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_pc", imem_addr_o, RV);
        reset = 1'b0;
        #1;
        chk("reset_first_req", {31'b0, imem_req_o}, 32'd1);
        $display("[TB] reset released, fetch PC %h", imem_addr_o);
    endtask

    // One clock cycle: drive inputs, compare DUT against model, advance model.
    task automatic step(input logic a_bu, input logic [31:0] a_bupc,
                        input logic a_csr, input logic [31:0] a_csrpc,
                        input logic a_pv, input logic a_pt, input logic [31:0] a_ppc,
                        input logic a_gnt, input logic a_rv, input logic a_rdy);
        int   unf;
        logic exp_req;
        logic exp_val;
        ent_t e;
        unf = 0;
        foreach (mq[i]) if (!mq[i].filled) unf++;
        if (m_disc + unf == 0) a_rv = 1'b0;

        bu_redirect_i     = a_bu;   bu_redirect_pc_i  = a_bupc;
        csr_redirect_i    = a_csr;  csr_redirect_pc_i = a_csrpc;
        pred_v_i          = a_pv;   pred_taken_i      = a_pt;
        pred_pc_i         = a_ppc;
        imem_gnt_i        = a_gnt;  imem_rvalid_i     = a_rv;
        imem_rdata_i      = $urandom;
        dec_ready_i       = a_rdy;
        #2;

        exp_req = ((mq.size() + m_disc) < DEPTH) && !a_bu && !a_csr;
        exp_val = (mq.size() > 0) && mq[0].filled;
        chk("req", {31'b0, imem_req_o}, {31'b0, exp_req});
        chk("addr", imem_addr_o, m_pc);
        chk("lookup", pred_lookup_pc_o, m_pc);
        chk("if_valid", {31'b0, if_valid_o}, {31'b0, exp_val});
        if (exp_val) begin
            chk("if_pc", if_pc_o, mq[0].pc);
            chk("if_instr", if_instr_o, mq[0].instr);
            chk("if_taken", {31'b0, if_pred_taken_o}, {31'b0, mq[0].taken});
            chk("if_pred_pc", if_pred_pc_o, mq[0].ppc);
        end
        if (if_valid_o && a_rdy) begin
            dv_pc.push_back(if_pc_o);
            dv_tk.push_back(if_pred_taken_o);
            dv_ppc.push_back(if_pred_pc_o);
            $display("[TB] deliver pc=%h instr=%h taken=%b target=%h",
                     if_pc_o, if_instr_o, if_pred_taken_o, if_pred_pc_o);
        end
        if (imem_req_o && a_gnt) gr_addr.push_back(imem_addr_o);

        if (a_bu || a_csr) begin
            m_disc = m_disc + unf - (a_rv ? 1 : 0);
            mq.delete();
            m_pc = (a_csr ? a_csrpc : a_bupc) & 32'hFFFF_FFFC;
        end else begin
            if (a_rv) begin
                if (m_disc > 0) begin
                    m_disc--;
                end else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            e = mq[i];
                            e.filled = 1'b1;
                            e.instr  = imem_rdata_i;
                            mq[i] = e;
                            break;
                        end
                    end
                end
            end
            if (exp_val && a_rdy) void'(mq.pop_front());
            if (exp_req && a_gnt) begin
                e.pc = m_pc; e.taken = a_pv & a_pt; e.ppc = a_ppc;
                e.filled = 1'b0; e.instr = '0;
                mq.push_back(e);
                m_pc = (a_pv && a_pt) ? a_ppc : m_pc + 32'd4;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        pred_pc_i = '0; bu_redirect_pc_i = '0; csr_redirect_pc_i = '0; imem_rdata_i = '0;
        do_reset();

        // Sequential fetch, everything always ready.
        clear_logs();
        repeat (12) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            chk("seq_grant", (i < gr_addr.size()) ? gr_addr[i] : 32'hDEAD_BEEF, EXP_B[i]);
            chk("seq_deliver", (i < dv_pc.size()) ? dv_pc[i] : 32'hDEAD_BEEF, EXP_B[i]);
            chk("seq_taken", (i < dv_tk.size()) ? {31'b0, dv_tk[i]} : 32'hDEAD_BEEF, 32'd0);
        end

        // Predicted-taken branch at 0x8 to 0x100.
        do_reset();
        clear_logs();
        repeat (16) step(0, 0, 0, 0, (m_pc == 32'h8), 1, 32'h100, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            chk("pred_grant", (i < gr_addr.size()) ? gr_addr[i] : 32'hDEAD_BEEF, EXP_C[i]);
            chk("pred_deliver", (i < dv_pc.size()) ? dv_pc[i] : 32'hDEAD_BEEF, EXP_C[i]);
        end
        chk("pred_taken_at_8", (dv_tk.size() > 2) ? {31'b0, dv_tk[2]} : 32'hDEAD_BEEF, 32'd1);
        chk("pred_target_at_8", (dv_ppc.size() > 2) ? dv_ppc[2] : 32'hDEAD_BEEF, 32'h100);
        chk("pred_not_taken_at_0", (dv_tk.size() > 0) ? {31'b0, dv_tk[0]} : 32'hDEAD_BEEF, 32'd0);

        // Decode stalled: buffer caps grants at its depth, nothing lost afterwards.
        do_reset();
        clear_logs();
        repeat (6) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("stall_grants", gr_addr.size(), DEPTH);
        repeat (10) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("stall_first_deliver", (dv_pc.size() > 0) ? dv_pc[0] : 32'hDEAD_BEEF, 32'h0);

        // Branch redirect with two requests outstanding.
        do_reset();
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step(1, 32'h200, 0, 0, 0, 0, 0, 1, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        clear_logs();
        repeat (6) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("bu_first_deliver", (dv_pc.size() > 0) ? dv_pc[0] : 32'hDEAD_BEEF, 32'h200);

        // Simultaneous redirects: CSR target wins.
        do_reset();
        clear_logs();
        step(1, 32'h300, 1, 32'h80, 0, 0, 0, 1, 0, 1);
        chk("csr_prio_addr", imem_addr_o, 32'h80);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("csr_prio_grant", (gr_addr.size() > 0) ? gr_addr[0] : 32'hDEAD_BEEF, 32'h80);

        // Redirect coinciding with the only outstanding response, then reset mid-stream.
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        step(1, 32'h43, 0, 0, 0, 0, 0, 1, 1, 1);
        clear_logs();
        repeat (6) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("same_cycle_deliver", (dv_pc.size() > 0) ? dv_pc[0] : 32'hDEAD_BEEF, 32'h40);
        do_reset();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 15) == 0), $urandom,
                 ($urandom_range(0, 31) == 0), $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Instruction-fetch front end sitting directly upstream of the branch predictor.
- Owns the fetch PC and drives it as the predictor lookup address.
- Selects the next PC from the predictor hit, branch-unit redirect, or CSR/trap redirect.
- Issues in-order requests to instruction memory and buffers responses with their PC and prediction metadata for decode.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, fetch-buffer entries; power of two, ≥2; also the cap on in-flight requests.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- pred_lookup_pc_o  out  XLEN  current fetch PC, driven to predictor lookup
- pred_pc_i  in  XLEN  predicted target for pred_lookup_pc_o
- pred_taken_i  in  1  predictor says taken
- pred_v_i  in  1  predictor hit valid
- bu_redirect_i  in  1  branch unit mispredict redirect
- bu_redirect_pc_i  in  XLEN  corrected PC
- csr_redirect_i  in  1  trap/xret redirect
- csr_redirect_pc_i  in  XLEN  trap/return PC
- imem_req_o  out  1  fetch request
- imem_addr_o  out  XLEN  fetch address (= pc_q)
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  in-order response valid
- imem_rdata_i  in  32  instruction word
- if_valid_o  out  1  buffered instruction valid to decode
- if_instr_o  out  32  instruction
- if_pc_o  out  XLEN  its PC
- if_pred_taken_o  out  1  prediction used at fetch
- if_pred_pc_o  out  XLEN  predicted target used at fetch
- dec_ready_i  in  1  decode accepts

Behaviour:
- Reset (async, active-high):
  - pc_q = RESET_VECTOR; buffer empty; discard_cnt = 0.
  - imem_req_o = 0 and if_valid_o = 0 while reset is high.
- First request is RESET_VECTOR, in the first cycle after reset deasserts.
- Predictor path: pred_lookup_pc_o = pc_q, combinational. take = pred_v_i & pred_taken_i.
- Request issue:
  - imem_req_o = (occ + discard_cnt < BUF_DEPTH) & ~bu_redirect_i & ~csr_redirect_i.
  - occ = allocated buffer entries.
  - While imem_req_o is high and no grant, imem_addr_o stays stable. Only a redirect may withdraw the request.
- Grant (req & gnt):
  - Allocate a tail entry {pc = pc_q, pred_taken = take, pred_pc = pred_pc_i, filled = 0}.
  - pc_q <= take ? pred_pc_i : pc_q + 4, modulo 2^XLEN.
- pc_q changes only on grant or redirect.
- Response (rvalid):
  - If discard_cnt > 0: drop the data and decrement discard_cnt.
  - Otherwise: write imem_rdata_i into the oldest unfilled entry and set filled.
  - rvalid with nothing outstanding is illegal; assert in simulation.
- Decode output:
  - if_valid_o = head entry filled.
  - Fields come from the head entry.
  - Pop when if_valid_o & dec_ready_i.
  - Pop, fill and allocate may all occur in the same cycle.
  - A response may fill the head and be presented the next cycle (1-cycle rvalid→if_valid latency).
- Redirect priority: csr_redirect_i over bu_redirect_i. In a redirect cycle:
  - pc_q <= selected redirect PC; any grant that cycle cannot happen (req is 0).
  - All buffer entries are cleared and if_valid_o is 0 the next cycle. A pop in the redirect cycle is still honoured by decode, but decode is flushed by the same redirect.
  - discard_cnt <= discard_cnt + (allocated unfilled entries) − (1 if rvalid this cycle). A response arriving in the redirect cycle is dropped.
- Redirects in consecutive cycles: each recomputes the counts; the last redirect's PC wins.
- Full: occ + discard_cnt == BUF_DEPTH → no request. Responses never need backpressure.
- Alignment: redirect PCs are 4-byte aligned. Bits [1:0] are forced to 0 on load.

Test Plan:
- Reset release, gnt and rvalid tied high, dec_ready = 1, no predictor hit → requests at 0x0, 0x4, 0x8, 0xC; if_pc_o follows in order with if_pred_taken_o = 0.
- Predictor hit at 0x8 with taken = 1, target 0x100 → fetch sequence 0x0, 0x4, 0x8, 0x100, 0x104; the 0x8 entry shows if_pred_taken_o = 1 and if_pred_pc_o = 0x100.
- dec_ready = 0 with BUF_DEPTH = 2 → exactly 2 grants, then imem_req_o = 0 until a pop; PCs held stable; no data lost.
- Two requests outstanding, then bu_redirect_i to 0x200 → both later responses dropped; discard_cnt reaches 0; the next delivered if_pc_o is 0x200.
- bu_redirect (0x300) and csr_redirect (0x80) in the same cycle → fetch resumes at 0x80.
- Redirect in the same cycle as rvalid, with one request outstanding → that response dropped, discard_cnt stays 0; assert reset mid-stream → outputs immediately 0 and restart at RESET_VECTOR.
